seq_arith_unit: RTL
===================

Name: seq_arith_unit

Overview:
- Parametrised, multi-cycle successor to the combinational 4-function arithmetic unit.
- Performs ADD, SUB, MUL and DIV on WIDTH-bit unsigned operands, exposing a carry/borrow flag and a divide-by-zero flag.
- MUL and DIV are iterative (one bit per cycle), so operand width scales without a large combinational array.
- Sits between the keypad/operand front end and the display/result path, using valid/ready handshakes on both sides.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..16); result width is 2*WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- sel  in  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  2*WIDTH  result word.
- carry  out  1  ADD carry-out / SUB borrow; 0 for MUL and DIV.
- div_by_zero  out  1  DIV with b==0; 0 otherwise.

Behaviour:
- Clock and reset: one clock domain; rst is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, result=0, carry=0, div_by_zero=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation: rst aborts any operation in progress. No result is emitted and the captured operands are discarded.
- Decoding: in_ready = (state==IDLE). A request is accepted on a rising edge where in_valid && in_ready. At that edge a, b and sel are registered; later changes on those inputs are ignored.
- State IDLE: on accept, ADD, SUB and DIV-by-zero go to DONE; MUL and DIV with b!=0 go to BUSY with the iteration counter set to WIDTH-1.
- State BUSY: one shift-add (MUL) or restoring shift-subtract (DIV) step per cycle. Exits to DONE after exactly WIDTH steps.
- State DONE: out_valid=1. result, carry and div_by_zero are held stable until out_valid && out_ready. On that edge the block returns to IDLE.
- No accept during DONE: a new request can be accepted one cycle after the output handshake at the earliest.
- Latency, counted in edges from the accepting edge to out_valid=1:
  - ADD, SUB, DIV-by-zero: 1.
  - MUL, DIV: WIDTH+1.
- ADD: result = {WIDTH'b0, (a+b) mod 2^WIDTH}; carry = bit WIDTH of a+b.
- SUB: result = {WIDTH'b0, (a-b) mod 2^WIDTH}; carry = (a<b), i.e. borrow.
- MUL: result = a*b, the full 2*WIDTH-bit product; carry=0.
- DIV, b!=0: result = {quotient, remainder}, quotient in the upper WIDTH bits; carry=0.
- DIV, b==0: quotient = all ones, remainder = a, div_by_zero=1.
- Boundary values: a=0 or b=0 in MUL still takes WIDTH+1 cycles (no early exit). Maximum operands give no overflow in MUL.
- Backpressure: out_ready may stay low indefinitely; outputs must not change while they wait.
- out_ready while out_valid=0: ignored.
- Opcode validity: all sel encodings are valid; there is no error state.

Decomposition:
- Shared package arith_pkg:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11;
  - FSM state encoding IDLE/BUSY/DONE.
- Sub-module iter_mul_div (WIDTH parameter):
  - holds the shared accumulator/shift registers for iterative multiply and restoring divide;
  - interface: start, mode, a, b, done, hi, lo.
- ADD, SUB and the FSM stay in seq_arith_unit.

Test Plan:
- ADD, WIDTH=4, a=9, b=8, out_ready=1 -> result=8'h01, carry=1, out_valid exactly 1 edge after accept.
- SUB, a=3, b=5 -> result=8'h0E, carry=1. Then a=5, b=3 -> result=8'h02, carry=0.
- MUL, a=15, b=15 -> result=8'hE1 at exactly 5 edges after accept, in_ready=0 throughout. With WIDTH=8: 200*250 -> 16'hC350 at 9 edges.
- DIV, a=13, b=4 -> result=8'h31, div_by_zero=0, latency 5. Then a=7, b=0 -> result=8'hF7, div_by_zero=1, latency 1.
- Backpressure: after MUL 6*7, hold out_ready=0 for 3 cycles while toggling a, b, sel and in_valid -> result stays 8'h2A, in_ready=0, no new accept. After the out_ready pulse, in_ready=1 on the next cycle.
- Reset mid-op: assert rst for 1 cycle during BUSY step 2 of DIV 9/2 -> out_valid never asserts for it, all outputs 0, in_ready=1. A following ADD 1+1 -> result=8'h02.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared opcodes, iterator modes and FSM encoding for the sequential arithmetic unit.
package arith_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/iter_mul_div.sv
// Iterative engine: shift-add multiply or restoring divide, one bit per cycle.
// After WIDTH steps: MUL leaves the product in {hi, lo}; DIV leaves quotient in lo, remainder in hi.
module iter_mul_div
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic             r_mode;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // One step of the selected algorithm, computed from the current registers
    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        w_sum    = {1'b0, r_hi} + {1'b0, r_b};
        w_add    = r_lo[0] ? w_sum : {1'b0, r_hi};
        w_shift  = {r_hi, r_lo[WIDTH-1]};
        w_trial  = w_shift - {1'b0, r_b};
        w_fits   = ~w_trial[WIDTH];
        if (r_mode == MODE_MUL) begin
            w_hi_nxt = w_add[WIDTH:1];
            w_lo_nxt = {w_add[0], r_lo[WIDTH-1:1]};
        end else begin
            w_hi_nxt = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], w_fits};
        end
    end

    // Operand load on start, then WIDTH steps counted down to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_mode <= MODE_MUL;
        end else if (start) begin
            r_hi   <= '0;
            r_lo   <= a;
            r_b    <= b;
            r_cnt  <= CNT_W'(WIDTH - 1);
            r_run  <= 1'b1;
            r_mode <= mode;
        end else if (r_run) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
            if (r_cnt == '0) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // done marks the cycle whose closing edge performs the final step
    assign done = r_run && (r_cnt == '0);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: rtl/seq_arith_unit.sv
// Multi-cycle ADD/SUB/MUL/DIV unit with valid/ready handshakes on both sides.
// ADD/SUB/DIV-by-zero finish on the accepting edge; MUL/DIV run WIDTH extra steps.
module seq_arith_unit
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               carry,
    output logic               div_by_zero
);

    localparam int unsigned RES_W = 2 * WIDTH;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             w_accept;
    logic             w_start;
    logic             w_iter_op;
    logic             w_b_zero;
    logic             w_mode;
    logic             w_done;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;

    logic [RES_W-1:0] r_result;
    logic             r_carry;
    logic             r_dbz;
    logic             r_use_iter;
    logic             r_iter_div;

    // Request decode and the single-cycle arithmetic
    always_comb begin
        w_b_zero  = (b == '0);
        w_iter_op = (sel == OP_MUL) || ((sel == OP_DIV) && !w_b_zero);
        w_accept  = in_valid && (r_state == IDLE);
        w_start   = w_accept && w_iter_op;
        w_mode    = (sel == OP_DIV) ? MODE_DIV : MODE_MUL;
        w_sum     = {1'b0, a} + {1'b0, b};
        w_diff    = {1'b0, a} - {1'b0, b};
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = w_iter_op ? BUSY : DONE;
            BUSY: if (w_done) w_state_nxt = DONE;
            DONE: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Result capture on accept; MUL/DIV results are read from the iterator once it stops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_dbz      <= 1'b0;
            r_use_iter <= 1'b0;
            r_iter_div <= 1'b0;
        end else if (w_accept) begin
            r_carry    <= 1'b0;
            r_dbz      <= 1'b0;
            r_use_iter <= 1'b0;
            r_iter_div <= 1'b0;
            case (sel)
                OP_ADD: begin
                    r_result <= {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
                    r_carry  <= w_sum[WIDTH];
                end
                OP_SUB: begin
                    r_result <= {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
                    r_carry  <= w_diff[WIDTH];
                end
                OP_MUL: begin
                    r_use_iter <= 1'b1;
                end
                default: begin
                    if (w_b_zero) begin
                        r_result <= {{WIDTH{1'b1}}, a};
                        r_dbz    <= 1'b1;
                    end else begin
                        r_use_iter <= 1'b1;
                        r_iter_div <= 1'b1;
                    end
                end
            endcase
        end
    end

    iter_mul_div #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .mode  (w_mode),
        .a     (a),
        .b     (b),
        .done  (w_done),
        .hi    (w_hi),
        .lo    (w_lo)
    );

    // Outputs decoded from registers; iterator registers hold still outside BUSY
    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign result      = r_use_iter ? (r_iter_div ? {w_lo, w_hi} : {w_hi, w_lo}) : r_result;
    assign carry       = r_carry;
    assign div_by_zero = r_dbz;

endmodule
